memory_miss_responder: RTL and testbench

// - Memory-side responder for D$ miss/eviction traffic: accepts req_valid_miss/req_info_miss/req_thread_id_miss pulses.
// - Buffers each request in a small FIFO and services it from a line-wide backing array after a fixed latency.
// - Returns rsp_valid_miss/rsp_data_miss/rsp_thread_id/rsp_bus_error to the cache, one response per accepted request, in order.

---
 rtl/memory_miss_responder_pkg.sv | 24 ++
 rtl/memory_miss_responder_fifo.sv | 53 +++++
 rtl/memory_miss_responder.sv | 156 +++++++++++++++
 tb/tb_memory_miss_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_miss_responder_pkg.sv
// Shared types and constants for the D$ miss/eviction memory responder.
package memory_miss_responder_pkg;

  localparam int DCACHE_LINE_WIDTH  = 128;
  localparam int THR_PER_CORE       = 4;
  localparam int THR_PER_CORE_WIDTH = 2;
  localparam int ADDR_WIDTH         = 32;
  localparam int MEM_LATENCY_DEF    = 20;
  localparam int MEM_LINES_DEF      = 1024;
  localparam int LINE_OFFSET_BITS   = $clog2(DCACHE_LINE_WIDTH / 8);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        addr;
    logic                         is_store;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;

  function automatic logic [ADDR_WIDTH-1:0] line_index(input logic [ADDR_WIDTH-1:0] addr);
    return addr >> LINE_OFFSET_BITS;
  endfunction

endpackage

// File: rtl/memory_miss_responder_fifo.sv
// Request FIFO for the memory responder; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module mem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = storage[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) storage[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/memory_miss_responder.sv
// Memory-side responder: queues D$ miss/eviction requests and answers each
// from a line-wide backing array after a fixed latency, strictly in order.
module memory_miss_responder
  import memory_miss_responder_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int MEM_LINES   = MEM_LINES_DEF,
  parameter bit STORE_ACK   = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid_miss,
  input  memory_request_t               req_info_miss,
  input  logic [THR_PER_CORE_WIDTH-1:0] req_thread_id_miss,
  output logic                          rsp_valid_miss,
  output logic [DCACHE_LINE_WIDTH-1:0]  rsp_data_miss,
  output logic [THR_PER_CORE_WIDTH-1:0] rsp_thread_id,
  output logic                          rsp_bus_error,
  output logic                          mem_busy,
  output logic                          overflow_err
);

  localparam int REQ_W = $bits(memory_request_t) + THR_PER_CORE_WIDTH;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int IDX_W = $clog2(MEM_LINES);

  logic [DCACHE_LINE_WIDTH-1:0] mem_array [MEM_LINES];

  logic                          fifo_full, fifo_empty, fifo_pop;
  logic [REQ_W-1:0]              fifo_pop_data;
  memory_request_t               pop_req;
  logic [THR_PER_CORE_WIDTH-1:0] pop_tid;

  mem_resp_state_t               state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  memory_request_t               svc_req_q, svc_req_d;
  logic [THR_PER_CORE_WIDTH-1:0] svc_tid_q, svc_tid_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [DCACHE_LINE_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [THR_PER_CORE_WIDTH-1:0] rsp_tid_q, rsp_tid_d;
  logic                          rsp_err_q, rsp_err_d;
  logic                          overflow_q, overflow_d;

  logic [ADDR_WIDTH-1:0]         svc_line;
  logic [IDX_W-1:0]              svc_idx;
  logic                          svc_bus_err;
  logic                          mem_we;

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_valid_miss),
    .push_data ({req_info_miss, req_thread_id_miss}),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop_req     = memory_request_t'(fifo_pop_data[REQ_W-1:THR_PER_CORE_WIDTH]);
  assign pop_tid     = fifo_pop_data[THR_PER_CORE_WIDTH-1:0];
  assign svc_line    = line_index(svc_req_q.addr);
  assign svc_bus_err = (svc_line >= ADDR_WIDTH'(MEM_LINES));
  assign svc_idx     = svc_line[IDX_W-1:0];

  // The response is computed on the last WAIT cycle so the registered
  // outputs pulse during the single RESP cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    svc_req_d   = svc_req_q;
    svc_tid_d   = svc_tid_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_tid_d   = '0;
    rsp_err_d   = 1'b0;
    fifo_pop    = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          svc_req_d = pop_req;
          svc_tid_d = pop_tid;
          cnt_d     = CNT_W'(MEM_LATENCY - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (svc_bus_err) begin
            rsp_valid_d = !svc_req_q.is_store || STORE_ACK;
            rsp_err_d   = rsp_valid_d;
          end else if (svc_req_q.is_store) begin
            mem_we      = 1'b1;
            rsp_valid_d = STORE_ACK;
            rsp_data_d  = STORE_ACK ? svc_req_q.data : '0;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_array[svc_idx];
          end
          rsp_tid_d = rsp_valid_d ? svc_tid_q : '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    overflow_d = overflow_q | (req_valid_miss & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      svc_req_q   <= '0;
      svc_tid_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tid_q   <= '0;
      rsp_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      svc_req_q   <= svc_req_d;
      svc_tid_q   <= svc_tid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_err_q   <= rsp_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // Backing store keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_array[svc_idx] <= svc_req_q.data;
  end

  assign rsp_valid_miss = rsp_valid_q;
  assign rsp_data_miss  = rsp_data_q;
  assign rsp_thread_id  = rsp_tid_q;
  assign rsp_bus_error  = rsp_err_q;
  assign overflow_err   = overflow_q;
  assign mem_busy       = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_memory_miss_responder.sv
// Self-checking bench: table-driven requests plus hand-written latency,
// overflow, reset and silent-store sequences, scored through response queues.
module tb_memory_miss_responder;
  import memory_miss_responder_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;
  localparam int LINES = 64;

  typedef struct {
    logic [1:0]   tid;
    logic [127:0] data;
    logic         err;
    string        name;
  } exp_t;

  typedef struct {
    logic         is_store;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [1:0]   tid;
    logic         exp_err;
    logic [127:0] exp_data;
    string        name;
  } vec_t;

  logic            clock;
  logic            reset;
  logic            req_valid_miss;
  logic            req_valid_na;
  memory_request_t req_info_miss;
  logic [1:0]      req_thread_id_miss;

  logic            rsp_valid_miss, rsp_bus_error, mem_busy, overflow_err;
  logic [127:0]    rsp_data_miss;
  logic [1:0]      rsp_thread_id;
  logic            rsp_valid_na, rsp_bus_error_na, mem_busy_na, overflow_na;
  logic [127:0]    rsp_data_na;
  logic [1:0]      rsp_thread_id_na;

  int tests_run    = 0;
  int tests_failed = 0;
  int na_rsp_count = 0;
  exp_t exp_q[$];
  exp_t na_q[$];
  exp_t mon_e;
  exp_t na_e;
  vec_t vecs[8];
  vec_t b2b[5];

  memory_miss_responder #(
    .MEM_LATENCY (LAT),
    .FIFO_DEPTH  (DEPTH),
    .MEM_LINES   (LINES),
    .STORE_ACK   (1'b1)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid_miss     (req_valid_miss),
    .req_info_miss      (req_info_miss),
    .req_thread_id_miss (req_thread_id_miss),
    .rsp_valid_miss     (rsp_valid_miss),
    .rsp_data_miss      (rsp_data_miss),
    .rsp_thread_id      (rsp_thread_id),
    .rsp_bus_error      (rsp_bus_error),
    .mem_busy           (mem_busy),
    .overflow_err       (overflow_err)
  );

  memory_miss_responder #(
    .MEM_LATENCY (LAT),
    .FIFO_DEPTH  (DEPTH),
    .MEM_LINES   (LINES),
    .STORE_ACK   (1'b0)
  ) dut_na (
    .clock              (clock),
    .reset              (reset),
    .req_valid_miss     (req_valid_na),
    .req_info_miss      (req_info_miss),
    .req_thread_id_miss (req_thread_id_miss),
    .rsp_valid_miss     (rsp_valid_na),
    .rsp_data_miss      (rsp_data_na),
    .rsp_thread_id      (rsp_thread_id_na),
    .rsp_bus_error      (rsp_bus_error_na),
    .mem_busy           (mem_busy_na),
    .overflow_err       (overflow_na)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compares one value and reports a failure line if it differs.
  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one request pulse on the selected DUT and records the expected response.
  task automatic applyStimulus(input bit to_na, input logic st, input logic [31:0] addr,
                               input logic [127:0] data, input logic [1:0] tid, input bit expect_rsp,
                               input logic [127:0] exp_data, input logic exp_err, input string name);
    exp_t e;
    @(negedge clock);
    req_info_miss.addr     = addr;
    req_info_miss.is_store = st;
    req_info_miss.data     = data;
    req_thread_id_miss     = tid;
    req_valid_miss         = !to_na;
    req_valid_na           = to_na;
    if (expect_rsp) begin
      e.tid  = tid;
      e.data = exp_data;
      e.err  = exp_err;
      e.name = name;
      if (to_na) na_q.push_back(e);
      else       exp_q.push_back(e);
    end
  endtask

  task automatic idleCycle();
    @(negedge clock);
    req_valid_miss = 1'b0;
    req_valid_na   = 1'b0;
  endtask

  // Waits until both responders are idle with nothing outstanding.
  task automatic waitDrain(input int budget, input string name);
    int k = 0;
    while ((exp_q.size() != 0 || na_q.size() != 0 || mem_busy || mem_busy_na) && k < budget) begin
      @(negedge clock);
      k++;
    end
    tests_run++;
    if (exp_q.size() != 0 || na_q.size() != 0 || mem_busy || mem_busy_na) begin
      tests_failed++;
      $display("[TB] FAIL %s_drain: got %0d/%0d outstanding after %0d cycles, expected 0",
               name, exp_q.size(), na_q.size(), budget);
    end
  endtask

  // Scoreboard for the acknowledging responder.
  always @(negedge clock) begin
    if (reset) begin
      if (rsp_valid_miss) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_rsp: got tid %0d data %h, expected no response",
                   rsp_thread_id, rsp_data_miss);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput({mon_e.name, "_data"}, rsp_data_miss, mon_e.data);
          checkOutput({mon_e.name, "_tid"}, 128'(rsp_thread_id), 128'(mon_e.tid));
          checkOutput({mon_e.name, "_err"}, 128'(rsp_bus_error), 128'(mon_e.err));
        end
      end else begin
        checkOutput("idle_rsp_data", rsp_data_miss, '0);
        checkOutput("idle_rsp_err", 128'(rsp_bus_error), '0);
      end
    end
  end

  // Scoreboard for the silent-store responder.
  always @(negedge clock) begin
    if (reset && rsp_valid_na) begin
      na_rsp_count++;
      if (na_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL na_unexpected_rsp: got tid %0d data %h, expected no response",
                 rsp_thread_id_na, rsp_data_na);
      end else begin
        na_e = na_q.pop_front();
        checkOutput({na_e.name, "_data"}, rsp_data_na, na_e.data);
        checkOutput({na_e.name, "_tid"}, 128'(rsp_thread_id_na), 128'(na_e.tid));
        checkOutput({na_e.name, "_err"}, 128'(rsp_bus_error_na), 128'(na_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    vecs[0] = '{1'b1, 32'h0000_0040, {16{8'h11}}, 2'd2, 1'b0, {16{8'h11}}, "st_40"};
    vecs[1] = '{1'b0, 32'h0000_0040, 128'h0,      2'd3, 1'b0, {16{8'h11}}, "ld_40"};
    vecs[2] = '{1'b1, 32'h0000_0000, {8{16'h5A5A}}, 2'd0, 1'b0, {8{16'h5A5A}}, "st_00"};
    vecs[3] = '{1'b0, 32'h0000_0400, 128'h0,      2'd1, 1'b1, 128'h0,      "ld_oob"};
    vecs[4] = '{1'b1, 32'h0000_0400, {16{8'hFF}}, 2'd2, 1'b1, 128'h0,      "st_oob"};
    vecs[5] = '{1'b0, 32'h0000_0000, 128'h0,      2'd3, 1'b0, {8{16'h5A5A}}, "ld_00_after_oob"};
    vecs[6] = '{1'b1, 32'h0000_03F0, {16{8'hC3}}, 2'd0, 1'b0, {16{8'hC3}}, "st_last"};
    vecs[7] = '{1'b0, 32'h0000_03FF, 128'h0,      2'd1, 1'b0, {16{8'hC3}}, "ld_last"};

    b2b[0] = '{1'b1, 32'h0000_0050, {16{8'hD0}}, 2'd0, 1'b0, {16{8'hD0}}, "b2b_st_50"};
    b2b[1] = '{1'b0, 32'h0000_0050, 128'h0,      2'd1, 1'b0, {16{8'hD0}}, "b2b_ld_50"};
    b2b[2] = '{1'b1, 32'h0000_0060, {16{8'hD1}}, 2'd2, 1'b0, {16{8'hD1}}, "b2b_st_60"};
    b2b[3] = '{1'b0, 32'h0000_0060, 128'h0,      2'd3, 1'b0, {16{8'hD1}}, "b2b_ld_60"};
    b2b[4] = '{1'b0, 32'h0000_0040, 128'h0,      2'd0, 1'b0, {16{8'h11}}, "b2b_ld_40"};

    reset              = 1'b0;
    req_valid_miss     = 1'b0;
    req_valid_na       = 1'b0;
    req_info_miss      = '0;
    req_thread_id_miss = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_rsp_valid", 128'(rsp_valid_miss), '0);
    checkOutput("reset_rsp_data", rsp_data_miss, '0);
    checkOutput("reset_rsp_tid", 128'(rsp_thread_id), '0);
    checkOutput("reset_rsp_err", 128'(rsp_bus_error), '0);
    checkOutput("reset_busy", 128'(mem_busy), '0);
    checkOutput("reset_overflow", 128'(overflow_err), '0);
    reset = 1'b1;

    applyStimulus(0, 1'b1, 32'h40, {16{8'hA5}}, 2'd1, 1, {16{8'hA5}}, 1'b0, "preload_st");
    idleCycle();
    waitDrain(50, "preload");

    // Load latency measured in cycles from the request cycle.
    applyStimulus(0, 1'b0, 32'h40, '0, 2'd1, 1, {16{8'hA5}}, 1'b0, "lat_ld");
    k = 0;
    do begin
      @(negedge clock);
      req_valid_miss = 1'b0;
      k++;
    end while (!rsp_valid_miss && k < 30);
    checkOutput("load_latency", 128'(k), 128'(LAT + 2));
    waitDrain(50, "latency");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, vecs[i].is_store, vecs[i].addr, vecs[i].data, vecs[i].tid, 1,
                    vecs[i].exp_data, vecs[i].exp_err, vecs[i].name);
      idleCycle();
      waitDrain(50, vecs[i].name);
    end

    for (int i = 0; i < 5; i++)
      applyStimulus(0, b2b[i].is_store, b2b[i].addr, b2b[i].data, b2b[i].tid, 1,
                    b2b[i].exp_data, b2b[i].exp_err, b2b[i].name);
    idleCycle();
    checkOutput("b2b5_overflow", 128'(overflow_err), '0);
    waitDrain(200, "b2b5");
    checkOutput("b2b5_overflow_end", 128'(overflow_err), '0);

    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1'b0, 32'h40, '0, 2'(i), (i < 5), {16{8'h11}}, 1'b0, $sformatf("ovf_ld%0d", i));
    idleCycle();
    checkOutput("b2b6_overflow", 128'(overflow_err), 128'(1));
    waitDrain(200, "b2b6");
    checkOutput("b2b6_overflow_sticky", 128'(overflow_err), 128'(1));

    // Reset while a load sits in WAIT; it must never respond.
    applyStimulus(0, 1'b0, 32'h40, '0, 2'd2, 0, '0, 1'b0, "rst_ld");
    idleCycle();
    @(negedge clock);
    checkOutput("pre_rst_busy", 128'(mem_busy), 128'(1));
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", 128'(rsp_valid_miss), '0);
    checkOutput("rst_busy", 128'(mem_busy), '0);
    checkOutput("rst_overflow", 128'(overflow_err), '0);
    checkOutput("rst_rsp_data", rsp_data_miss, '0);
    @(negedge clock);
    reset = 1'b1;
    repeat (LAT * 3) @(negedge clock);
    checkOutput("post_rst_busy", 128'(mem_busy), '0);

    applyStimulus(1, 1'b1, 32'h80, {16{8'h77}}, 2'd2, 0, '0, 1'b0, "na_st");
    applyStimulus(1, 1'b0, 32'h80, '0, 2'd3, 1, {16{8'h77}}, 1'b0, "na_ld");
    idleCycle();
    waitDrain(100, "na");
    checkOutput("na_rsp_count", 128'(na_rsp_count), 128'(1));
    checkOutput("na_overflow", 128'(overflow_na), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
